audio_fir_decim: RTL and testbench

- Decimating real-valued low-pass FIR that sits directly downstream of the FM demodulator.
- Consumes the demodulator's 32-bit fixed-point sample stream and its one-cycle write strobe.
- Produces one filtered audio sample every DECIM accepted inputs.
- Uses a single time-multiplexed multiply-accumulate (MAC) unit over a circular history buffer.

---
 rtl/audio_fir_decim_if.sv | 19 +
 rtl/audio_fir_decim.sv | 141 ++++++++++++++
 tb/tb_audio_fir_decim.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_fir_decim_if.sv
// Sample-stream bundle between the FM demodulator, the decimating FIR and
// the downstream audio consumer.
interface audio_fir_decim_if;
    logic        rd_en_in;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        wr_en_out;
    logic        overrun;

    modport master (
        output rd_en_in, data_in,
        input  data_out, wr_en_out, overrun
    );

    modport slave (
        input  rd_en_in, data_in,
        output data_out, wr_en_out, overrun
    );
endinterface

// File: rtl/audio_fir_decim.sv
// Decimating real-valued low-pass FIR. The filter uses one time-multiplexed
// MAC over a circular history buffer of NUM_TAPS+DECIM words and emits one
// sample every DECIM accepted inputs.
// Optional macro FIR_DEQUANT_ROUND_EN: round-half-up per-tap dequantization
// instead of truncation toward minus infinity.
module audio_fir_decim #(
    parameter int                    NUM_TAPS = 32,
    parameter int                    DECIM    = 8,
    parameter int                    BITS     = 10,
    parameter logic [NUM_TAPS*32-1:0] COEFFS  = {{((NUM_TAPS-1)*32){1'b0}}, 32'd1024}
) (
    input  logic           clk,
    input  logic           reset,
    audio_fir_decim_if.slave bus
);

    localparam int unsigned DEPTH = NUM_TAPS + DECIM;
    localparam int          AW    = $clog2(DEPTH);
    localparam int          PW    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int          KW    = $clog2(NUM_TAPS);

    typedef enum logic {
        S_IDLE,
        S_MAC
    } state_t;

    logic [31:0]        mem_q [DEPTH];
    logic [AW-1:0]      wptr_q;
    logic [PW-1:0]      phase_q;
    logic               trigger;

    state_t             state_q, state_d;
    logic [AW-1:0]      base_q, base_d;
    logic [KW-1:0]      k_q, k_d;
    logic [31:0]        acc_q, acc_d;
    logic [31:0]        dout_q, dout_d;
    logic               wr_q, wr_d;
    logic               ov_q, ov_d;

    logic [AW-1:0]      rd_addr;
    logic signed [31:0] sample;
    logic signed [31:0] coef;
    logic signed [31:0] prod;
    logic signed [31:0] term;

    assign trigger = bus.rd_en_in && (phase_q == PW'(DECIM - 1));

    // History buffer, write pointer and phase counter advance on every accepted sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            phase_q <= '0;
        end else if (bus.rd_en_in) begin
            mem_q[wptr_q] <= bus.data_in;
            wptr_q        <= (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
            phase_q       <= (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + 1'b1;
        end
    end

    // Tap k reads the sample k accepts older than the snapshot, modulo buffer depth.
    always_comb begin
        rd_addr = '0;
        if (base_q >= AW'(k_q)) begin
            rd_addr = base_q - AW'(k_q);
        end else begin
            rd_addr = base_q + AW'(DEPTH) - AW'(k_q);
        end
        sample = $signed(mem_q[rd_addr]);
        coef   = $signed(COEFFS[int'(k_q)*32 +: 32]);
        prod   = sample * coef;
`ifdef FIR_DEQUANT_ROUND_EN
        term   = (prod + (32'sd1 <<< (BITS - 1))) >>> BITS;
`else
        term   = prod >>> BITS;
`endif
    end

    // FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            dout_q  <= '0;
            wr_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            dout_q  <= dout_d;
            wr_q    <= wr_d;
            ov_q    <= ov_d;
        end
    end

    // Next-state: start on a trigger in IDLE, one tap per cycle in MAC, flag dropped triggers.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        k_d     = k_q;
        acc_d   = acc_q;
        dout_d  = dout_q;
        wr_d    = 1'b0;
        ov_d    = ov_q;
        unique case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    base_d  = wptr_q;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_q + term;
                if (trigger) begin
                    ov_d = 1'b1;
                end
                if (k_q == KW'(NUM_TAPS - 1)) begin
                    dout_d  = acc_q + term;
                    wr_d    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.data_out  = dout_q;
    assign bus.wr_en_out = wr_q;
    assign bus.overrun   = ov_q;

endmodule

// File: tb/tb_audio_fir_decim.sv
// Self-checking bench for audio_fir_decim: four instances in different
// configurations, an ideal-history reference filter and per-instance
// scoreboards of expected (value, cycle) pairs.
module tb_audio_fir_decim;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // 0: defaults, 1: 4-tap moving average, 2: rounding, 3: overrun
    int nt  [4] = '{32, 4, 2, 4};
    int dec [4] = '{8, 1, 1, 1};
    int coef [4][32];

    int   hist [4][$];
    int   phase [4];
    int   last_start [4];
    bit   ov_m [4];
    exp_t sb [4][$];
    int   outcnt [4];
    int   last_wr [4];

    logic        rd_v   [4];
    logic [31:0] din_v  [4];
    logic        wr_v   [4];
    logic [31:0] dout_v [4];
    logic        ov_v   [4];

    audio_fir_decim_if bus0 ();
    audio_fir_decim_if bus1 ();
    audio_fir_decim_if bus2 ();
    audio_fir_decim_if bus3 ();

    assign bus0.rd_en_in = rd_v[0];
    assign bus0.data_in  = din_v[0];
    assign bus1.rd_en_in = rd_v[1];
    assign bus1.data_in  = din_v[1];
    assign bus2.rd_en_in = rd_v[2];
    assign bus2.data_in  = din_v[2];
    assign bus3.rd_en_in = rd_v[3];
    assign bus3.data_in  = din_v[3];

    assign wr_v[0] = bus0.wr_en_out;
    assign wr_v[1] = bus1.wr_en_out;
    assign wr_v[2] = bus2.wr_en_out;
    assign wr_v[3] = bus3.wr_en_out;
    assign dout_v[0] = bus0.data_out;
    assign dout_v[1] = bus1.data_out;
    assign dout_v[2] = bus2.data_out;
    assign dout_v[3] = bus3.data_out;
    assign ov_v[0] = bus0.overrun;
    assign ov_v[1] = bus1.overrun;
    assign ov_v[2] = bus2.overrun;
    assign ov_v[3] = bus3.overrun;

    audio_fir_decim u_def (.clk(clk), .reset(reset), .bus(bus0));

    audio_fir_decim #(
        .NUM_TAPS(4), .DECIM(1), .BITS(10),
        .COEFFS({32'd256, 32'd256, 32'd256, 32'd256})
    ) u_ma (.clk(clk), .reset(reset), .bus(bus1));

    audio_fir_decim #(
        .NUM_TAPS(2), .DECIM(1), .BITS(10),
        .COEFFS({32'd0, 32'd512})
    ) u_rnd (.clk(clk), .reset(reset), .bus(bus2));

    audio_fir_decim #(
        .NUM_TAPS(4), .DECIM(1), .BITS(10),
        .COEFFS({32'd0, 32'd0, 32'd512, 32'd1024})
    ) u_ov (.clk(clk), .reset(reset), .bus(bus3));

    // Reference filter over the ideal history (newest first, missing history = 0).
    function automatic int model_fir(input int id);
        int acc;
        int s;
        int p;
        int t;
        acc = 0;
        for (int k = 0; k < nt[id]; k++) begin
            s = (k < hist[id].size()) ? hist[id][k] : 0;
            p = s * coef[id][k];
`ifdef FIR_DEQUANT_ROUND_EN
            t = (p + (1 << 9)) >>> 10;
`else
            t = p >>> 10;
`endif
            acc = acc + t;
        end
        return acc;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            hist[i].delete();
            sb[i].delete();
            phase[i]      = 0;
            last_start[i] = -1000;
            ov_m[i]       = 1'b0;
        end
    endtask

    // Called at a negedge; drives one accepted sample and updates the model.
    task automatic drive(input int id, input int x);
        rd_v[id]  = 1'b1;
        din_v[id] = x;
        hist[id].push_front(x);
        if (hist[id].size() > nt[id]) void'(hist[id].pop_back());
        if (phase[id] == dec[id] - 1) begin
            phase[id] = 0;
            if (cyc > last_start[id] + nt[id]) begin
                sb[id].push_back('{model_fir(id), cyc + nt[id] + 1});
                last_start[id] = cyc;
            end else begin
                ov_m[id] = 1'b1;
            end
        end else begin
            phase[id] = phase[id] + 1;
        end
        @(posedge clk);
        @(negedge clk);
        rd_v[id] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic wait_drain(input int id);
        for (int t = 0; t < 400 && sb[id].size() != 0; t++) @(negedge clk);
        checks++;
        if (sb[id].size() != 0) begin
            failures++;
            $display("FAIL drain[%0d]: %0d outputs still pending, required 0", id, sb[id].size());
        end
    endtask

    // Scoreboard: every output pulse is popped and compared for value, cycle and spacing.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (wr_v[i] === 1'b1) begin
                outcnt[i]++;
                checks++;
                if (cyc - last_wr[i] < nt[i] + 1) begin
                    failures++;
                    $display("FAIL spacing[%0d]: pulse %0d cycles after previous, required >= %0d",
                             i, cyc - last_wr[i], nt[i] + 1);
                end
                last_wr[i] = cyc;
                checks++;
                if (sb[i].size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_out[%0d]: pulse with data %0d at cycle %0d, required none",
                             i, $signed(dout_v[i]), cyc);
                end else begin
                    e = sb[i].pop_front();
                    if (dout_v[i] !== 32'(e.val)) begin
                        failures++;
                        $display("FAIL data[%0d]: got %0d, required %0d", i, $signed(dout_v[i]), e.val);
                    end
                    checks++;
                    if (cyc !== e.cyc) begin
                        failures++;
                        $display("FAIL latency[%0d]: output at cycle %0d, required %0d", i, cyc, e.cyc);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        do_reset(3);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dout_v[i] !== 32'd0) begin
                failures++;
                $display("FAIL reset_data[%0d]: got %0d, required 0", i, dout_v[i]);
            end
            checks++;
            if (wr_v[i] !== 1'b0) begin
                failures++;
                $display("FAIL reset_wr[%0d]: got %b, required 0", i, wr_v[i]);
            end
            checks++;
            if (ov_v[i] !== 1'b0) begin
                failures++;
                $display("FAIL reset_ov[%0d]: got %b, required 0", i, ov_v[i]);
            end
        end
    endtask

    task automatic test_passthrough();
        int base;
        do_reset(1);
        base = outcnt[0];
        for (int i = 1; i <= 16; i++) begin
            drive(0, i);
            idle(39);
        end
        wait_drain(0);
        checks++;
        if (outcnt[0] - base !== 2) begin
            failures++;
            $display("FAIL pass_count: got %0d pulses, required 2", outcnt[0] - base);
        end
        checks++;
        if (ov_v[0] !== 1'b0) begin
            failures++;
            $display("FAIL pass_ov: got %b, required 0", ov_v[0]);
        end
    endtask

    task automatic test_moving_average();
        int base;
        do_reset(1);
        base = outcnt[1];
        for (int i = 1; i <= 4; i++) begin
            drive(1, 4 * i);
            idle(5);
        end
        wait_drain(1);
        checks++;
        if (outcnt[1] - base !== 4) begin
            failures++;
            $display("FAIL ma_count: got %0d pulses, required 4", outcnt[1] - base);
        end
    endtask

    task automatic test_rounding();
        int base;
        do_reset(1);
        base = outcnt[2];
        drive(2, -1);
        wait_drain(2);
        checks++;
        if (outcnt[2] - base !== 1) begin
            failures++;
            $display("FAIL rnd_count: got %0d pulses, required 1", outcnt[2] - base);
        end
    endtask

    task automatic test_overrun();
        int base;
        do_reset(1);
        base = outcnt[3];
        drive(3, 1);
        checks++;
        if (ov_v[3] !== 1'b0) begin
            failures++;
            $display("FAIL ov_first: got %b, required 0", ov_v[3]);
        end
        drive(3, 2);
        checks++;
        if (ov_v[3] !== 1'b1) begin
            failures++;
            $display("FAIL ov_second: got %b, required 1", ov_v[3]);
        end
        for (int i = 3; i <= 10; i++) drive(3, i);
        wait_drain(3);
        idle(6);
        checks++;
        if (outcnt[3] - base !== 2) begin
            failures++;
            $display("FAIL ov_count: got %0d pulses, required 2", outcnt[3] - base);
        end
        checks++;
        if (ov_v[3] !== ov_m[3]) begin
            failures++;
            $display("FAIL ov_sticky: got %b, required %b", ov_v[3], ov_m[3]);
        end
    endtask

    task automatic test_reset_mid_mac();
        int base;
        do_reset(1);
        drive(1, 7);
        idle(5);
        drive(1, 9);
        idle(5);
        wait_drain(1);
        drive(1, 100);
        idle(1);
        do_reset(1);
        base = outcnt[1];
        checks++;
        if (dout_v[1] !== 32'd0) begin
            failures++;
            $display("FAIL mid_reset_data: got %0d, required 0", dout_v[1]);
        end
        checks++;
        if (ov_v[1] !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_ov: got %b, required 0", ov_v[1]);
        end
        idle(10);
        checks++;
        if (outcnt[1] - base !== 0) begin
            failures++;
            $display("FAIL mid_reset_abort: got %0d pulses, required 0", outcnt[1] - base);
        end
        drive(1, 40);
        wait_drain(1);
        checks++;
        if (outcnt[1] - base !== 1) begin
            failures++;
            $display("FAIL mid_reset_count: got %0d pulses, required 1", outcnt[1] - base);
        end
    endtask

    task automatic test_pointer_wrap();
        int base;
        do_reset(1);
        base = outcnt[1];
        for (int i = 0; i < 50; i++) begin
            drive(1, i * 37 - 500);
            idle(5);
        end
        wait_drain(1);
        checks++;
        if (outcnt[1] - base !== 50) begin
            failures++;
            $display("FAIL wrap_count: got %0d pulses, required 50", outcnt[1] - base);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rd_v[i]    = 1'b0;
            din_v[i]   = '0;
            outcnt[i]  = 0;
            last_wr[i] = -1000;
            for (int k = 0; k < 32; k++) coef[i][k] = 0;
        end
        coef[0][0] = 1024;
        for (int k = 0; k < 4; k++) coef[1][k] = 256;
        coef[2][0] = 512;
        coef[3][0] = 1024;
        coef[3][1] = 512;
        model_clear();
        @(negedge clk);

        test_reset();
        test_passthrough();
        test_moving_average();
        test_rounding();
        test_overrun();
        test_reset_mid_mac();
        test_pointer_wrap();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
